// File: rtl/sw4_pkg.sv
// Shared types and constants for the sw4_debounce switch front end.
package sw4_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        SETTLE = 1'b1
    } sw4_state_t;

    localparam int SW4_STABLE_CYCLES_DEF = 50000;
    localparam int SW4_CNT_W_DEF         = 16;

    // Positions of the CALCOMP operands within the switch vector.
    localparam int SW4_A = 3;
    localparam int SW4_B = 2;
    localparam int SW4_C = 1;
    localparam int SW4_D = 0;

endpackage

// File: rtl/sw4_sync.sv
// Two-flop synchroniser of parameterised width; only the second stage is
// meant to be consumed by downstream logic.
module sw4_sync
    import sw4_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] q_out
);

    logic [WIDTH-1:0] s1_d, s1_q;
    logic [WIDTH-1:0] s2_d, s2_q;

    always_comb begin
        s1_d = d_in;
        s2_d = s1_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    assign q_out = s2_q;

endmodule

// File: rtl/sw4_debounce.sv
// Synchronises and debounces four board switches as one vector and drives the
// CALCOMP a/b/c/d inputs. Define SW4_CHG_COUNT_EN to add the chg_count output.
module sw4_debounce
    import sw4_pkg::*;
#(
    parameter int STABLE_CYCLES = SW4_STABLE_CYCLES_DEF,
    parameter int CNT_W         = SW4_CNT_W_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] sw_in,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       d,
    output logic       changed,
    output logic       busy
`ifdef SW4_CHG_COUNT_EN
    ,
    output logic [7:0] chg_count
`endif
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    logic [3:0] s2;

    sw4_sync #(.WIDTH(4)) u_sync (
        .clk   (clk),
        .rst   (rst),
        .d_in  (sw_in),
        .q_out (s2)
    );

    sw4_state_t       state_d, state_q;
    logic [3:0]       cand_d, cand_q;
    logic [3:0]       stable_d, stable_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic             changed_d, changed_q;
    logic             busy_d, busy_q;

    // A bounce back to the old value beats a new candidate, which beats acceptance.
    always_comb begin
        state_d   = state_q;
        cand_d    = cand_q;
        stable_d  = stable_q;
        cnt_d     = cnt_q;
        changed_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (s2 != stable_q) begin
                    state_d = SETTLE;
                    cand_d  = s2;
                    cnt_d   = '0;
                end
            end
            SETTLE: begin
                if (s2 == stable_q) begin
                    state_d = IDLE;
                end else if (s2 != cand_q) begin
                    cand_d = s2;
                    cnt_d  = '0;
                end else if (cnt_q == CNT_MAX) begin
                    stable_d  = cand_q;
                    changed_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == SETTLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cand_q    <= '0;
            stable_q  <= '0;
            cnt_q     <= '0;
            changed_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cand_q    <= cand_d;
            stable_q  <= stable_d;
            cnt_q     <= cnt_d;
            changed_q <= changed_d;
            busy_q    <= busy_d;
        end
    end

    assign a       = stable_q[SW4_A];
    assign b       = stable_q[SW4_B];
    assign c       = stable_q[SW4_C];
    assign d       = stable_q[SW4_D];
    assign changed = changed_q;
    assign busy    = busy_q;

`ifdef SW4_CHG_COUNT_EN
    logic [7:0] chg_count_d, chg_count_q;

    always_comb begin
        chg_count_d = chg_count_q;
        if (changed_q) begin
            chg_count_d = chg_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            chg_count_q <= 8'd0;
        end else begin
            chg_count_q <= chg_count_d;
        end
    end

    assign chg_count = chg_count_q;
`endif

endmodule

// File: doc/sw4_debounce.md
Name: sw4_debounce

Overview:
- Front-end stage that drives the a/b/c/d inputs of the CALCOMP combinational comparator from four raw board switches.
- Synchronises the 4-bit switch vector into the clock domain and debounces it as one vector.
- Presents a stable, registered a,b,c,d and a one-cycle strobe on every accepted change.

Parameters:
- STABLE_CYCLES, 50000, consecutive cycles the synchronised vector must hold a new value before it is accepted; legal range 2..2**CNT_W.
- CNT_W, 16, settle-counter width; must hold STABLE_CYCLES-1.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- sw_in  input  4  raw switches; bit3=a, bit2=b, bit1=c, bit0=d; asynchronous, may bounce
- a  output  1  debounced switch 3, registered
- b  output  1  debounced switch 2, registered
- c  output  1  debounced switch 1, registered
- d  output  1  debounced switch 0, registered
- changed  output  1  one-cycle pulse in the cycle after {a,b,c,d} updates
- busy  output  1  high while in SETTLE

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is synchronous, active-high; it wins over all other activity.
- Reset values: sync stages=0000, cand=0000, stable {a,b,c,d}=0000, cnt=0, state=IDLE, changed=0, busy=0. Downstream CALCOMP out is therefore 1 after reset.
- Synchroniser: two flops, s1<=sw_in, s2<=s1. Only s2 is used downstream.
- State IDLE:
  - If s2 != stable: go to SETTLE, cand<=s2, cnt<=0.
  - Otherwise stay in IDLE.
- State SETTLE, in priority order:
  - s2==stable (bounce back to the old value): go to IDLE. No update, no strobe.
  - s2 != cand (a different new value): cand<=s2, cnt<=0, stay in SETTLE.
  - cnt==STABLE_CYCLES-1: stable<=cand, changed<=1 on the following cycle, go to IDLE.
  - Otherwise: cnt<=cnt+1.
- Latency: count the first edge that samples a new clean sw_in value as edge 1. {a,b,c,d} update on edge STABLE_CYCLES+3. changed is high for exactly the one cycle after that edge.
- Updates are atomic: all four outputs change on the same edge, never bit-by-bit. CALCOMP therefore never sees an intermediate code.
- Multi-bit changes are accepted as one event; skewed switch edges simply restart settling.
- cnt never wraps; it stops at STABLE_CYCLES-1.
- busy = (state==SETTLE), registered with the state.
- Reset asserted mid-SETTLE: the pending candidate is discarded, outputs return to 0000, and no strobe is issued.

Optional Feature:
- Macro: SW4_CHG_COUNT_EN.
- Defined: adds output port chg_count [7:0]. It increments by 1 on each changed pulse, wraps 255->0, and resets to 0.
- Undefined: the port and its counter do not exist. All other behaviour is identical.

Decomposition:
- Package sw4_pkg holds:
  - state typedef sw4_state_t {IDLE, SETTLE}
  - default constants SW4_STABLE_CYCLES_DEF=50000 and SW4_CNT_W_DEF=16
  - bit-index constants SW4_A=3, SW4_B=2, SW4_C=1, SW4_D=0
- One natural sub-module: sw4_sync, a parameterised-width 2-flop synchroniser instantiated with width 4.
- FSM, counter and output registers stay in the top module.

Test Plan (bench uses STABLE_CYCLES=4 and CNT_W=3; CALCOMP instantiated downstream):
- Reset: hold rst for 2 cycles with sw_in=1111 -> abcd=0000, changed=0, busy=0, CALCOMP out=1.
- Clean change: sw_in 0000->1100 held -> abcd=1100 on edge 7, changed high for 1 cycle, busy high for 4 cycles, CALCOMP out 1->0.
- Bounce-back: sw_in 0000->0011 for 3 cycles, then back to 0000 -> abcd stays 0000, no changed pulse, busy drops, CALCOMP out stays 1.
- Restart: sw_in 0000->0010 for 3 cycles, then 0011 held -> abcd=0011 on edge 7 after the 0011 change, with a single changed pulse and no 0010 update.
- Mid-SETTLE reset: sw_in 0000->1010, assert rst at edge 4 -> abcd=0000, busy=0, changed never pulses; after release, abcd=1010 on edge 7 of the resumed sampling.
- SW4_CHG_COUNT_EN: 257 alternating accepted changes -> chg_count goes 255->0->1, exactly one increment per changed pulse.
